ps2_host_ctrl: RTL

Host-to-device PS/2 command controller. Accepts single-byte commands from game logic (LED update 0xED + argument, reset 0xFF, typematic 0xF3), runs the PS/2 host transmit sequence on the shared open-drain clock/data lines, and waits for the keyboard's 0xFA acknowledge, retrying on 0xFE. It sits beside the scancode receiver on the same PS/2 pins. It masks that receiver during transmit frames and consumes its byte output for acknowledge detection.

---
 rtl/ps2_host_ctrl_if.sv | 26 ++
 rtl/ps2_host_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_ctrl_if.sv
// Command/response bus between game logic, the scancode receiver and ps2_host_ctrl.
// Latency: none, plain wires.
// Backpressure: cmd_valid/cmd_ready handshake; rx_valid is a strobe with no ready.
// Signals: cmd_valid/cmd_data/cmd_ready command request; rx_byte/rx_valid receiver output;
//   rx_mask receiver discard request; done/error result pulses; err_code error reason.
interface ps2_host_ctrl_if;
  logic       cmd_valid;
  logic [7:0] cmd_data;
  logic       cmd_ready;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_mask;
  logic       done;
  logic       error;
  logic [1:0] err_code;

  modport master (
    output cmd_valid, cmd_data, rx_byte, rx_valid,
    input  cmd_ready, rx_mask, done, error, err_code
  );

  modport slave (
    input  cmd_valid, cmd_data, rx_byte, rx_valid,
    output cmd_ready, rx_mask, done, error, err_code
  );
endinterface

// File: rtl/ps2_host_ctrl.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, 11-clock frame, wait for 0xFA (retry on 0xFE).
// Latency: accept -> clock inhibit 1 cycle; pin falling edge -> internal fe 6 cycles; data_oe follows fe by 1 cycle.
// Backpressure: cmd_ready only in IDLE, so a new command waits for the current one to finish.
// Ports: clk, rst (synchronous, active-low); ps2_clk_i/ps2_data_i raw pin levels;
//   ps2_clk_oe/ps2_data_oe pull-low enables; bus (slave modport) carries the command handshake,
//   the receiver byte stream, rx_mask, done/error pulses and err_code.
module ps2_host_ctrl #(
  parameter int INHIBIT_CYC = 5000,
  parameter int TIMEOUT_CYC = 1000000,
  parameter int MAX_RETRY   = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ps2_clk_i,
  input  logic           ps2_data_i,
  output logic           ps2_clk_oe,
  output logic           ps2_data_oe,
  ps2_host_ctrl_if.slave bus
);

  // One counter serves both the inhibit interval and the timeouts; it is
  // cleared on every state change, so it is sized for the larger of the two.
  localparam int CNT_MAX = (TIMEOUT_CYC > INHIBIT_CYC) ? TIMEOUT_CYC : INHIBIT_CYC;
  localparam int TW      = $clog2(CNT_MAX + 1);
  localparam logic [TW-1:0] INH_LAST = TW'(INHIBIT_CYC - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  localparam logic [7:0] BYTE_ACK    = 8'hFA;
  localparam logic [7:0] BYTE_RESEND = 8'hFE;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_RTS,
    S_SEND,
    S_WAIT
  } state_t;

  // ---------------------------------------------------------------------
  // Pin conditioning. Sync flops reset to 1 because an idle bus floats high.
  // ---------------------------------------------------------------------
  logic       clk_s1_q, clk_s2_q;
  logic       dat_s1_q, dat_s2_q;
  logic       clk_f_q;
  logic [1:0] flt_cnt_q;
  logic       fe_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      clk_s1_q  <= 1'b1;
      clk_s2_q  <= 1'b1;
      dat_s1_q  <= 1'b1;
      dat_s2_q  <= 1'b1;
      clk_f_q   <= 1'b1;
      flt_cnt_q <= '0;
      fe_q      <= 1'b0;
    end else begin
      clk_s1_q <= ps2_clk_i;
      clk_s2_q <= clk_s1_q;
      dat_s1_q <= ps2_data_i;
      dat_s2_q <= dat_s1_q;
      fe_q     <= 1'b0;
      // flt_cnt_q counts consecutive samples disagreeing with the filtered
      // level; the fourth such sample flips it (and flags a falling edge).
      if (clk_s2_q == clk_f_q) begin
        flt_cnt_q <= '0;
      end else if (flt_cnt_q == 2'd3) begin
        clk_f_q   <= clk_s2_q;
        flt_cnt_q <= '0;
        fe_q      <= ~clk_s2_q;
      end else begin
        flt_cnt_q <= flt_cnt_q + 2'd1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Transaction FSM
  // ---------------------------------------------------------------------
  state_t          state_q, state_d;
  logic [TW-1:0]   cnt_q, cnt_d;
  logic [3:0]      nbit_q, nbit_d;
  logic [1:0]      retry_q, retry_d;
  logic [8:0]      frame_q, frame_d;      // {odd parity, command byte}
  logic            data_oe_q, data_oe_d;
  logic            done_q, done_d;
  logic            error_q, error_d;
  logic [1:0]      err_code_q, err_code_d;
  logic            abort;
  logic [1:0]      abort_code;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      nbit_q     <= '0;
      retry_q    <= '0;
      frame_q    <= '0;
      data_oe_q  <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      err_code_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      nbit_q     <= nbit_d;
      retry_q    <= retry_d;
      frame_q    <= frame_d;
      data_oe_q  <= data_oe_d;
      done_q     <= done_d;
      error_q    <= error_d;
      err_code_q <= err_code_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + 1'b1;
    nbit_d     = nbit_q;
    retry_d    = retry_q;
    frame_d    = frame_q;
    data_oe_d  = data_oe_q;
    done_d     = 1'b0;
    error_d    = 1'b0;
    err_code_d = err_code_q;
    abort      = 1'b0;
    abort_code = 2'd0;

    case (state_q)
      S_IDLE: begin
        data_oe_d = 1'b0;
        cnt_d     = '0;
        if (bus.cmd_valid) begin
          frame_d = {~^bus.cmd_data, bus.cmd_data};
          retry_d = '0;
          state_d = S_INHIBIT;
        end
      end

      S_INHIBIT: begin
        // Raise the start bit one cycle before the clock is released.
        if (cnt_q == INH_LAST) begin
          data_oe_d = 1'b1;
          state_d   = S_RTS;
        end
      end

      S_RTS: begin
        nbit_d  = '0;
        state_d = S_SEND;
      end

      S_SEND: begin
        if (fe_q) begin
          cnt_d = '0;
          if (nbit_q == 4'd10) begin
            // Eleventh falling edge: device should be pulling data low as ack.
            data_oe_d = 1'b0;
            if (!dat_s2_q) begin
              state_d = S_WAIT;
            end else begin
              abort      = 1'b1;
              abort_code = 2'd1;
            end
          end else begin
            nbit_d = nbit_q + 4'd1;
            if (nbit_q < 4'd8) begin
              data_oe_d = ~frame_q[nbit_q[2:0]];
            end else if (nbit_q == 4'd8) begin
              data_oe_d = ~frame_q[8];
            end else begin
              data_oe_d = 1'b0;                 // stop bit: release
            end
          end
        end else if (cnt_q == TMO_LAST) begin
          abort      = 1'b1;
          abort_code = 2'd2;
        end
      end

      S_WAIT: begin
        if (bus.rx_valid && bus.rx_byte == BYTE_ACK) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (bus.rx_valid && bus.rx_byte == BYTE_RESEND) begin
          if (int'(retry_q) < MAX_RETRY) begin
            retry_d = retry_q + 2'd1;
            state_d = S_INHIBIT;
          end else begin
            abort      = 1'b1;
            abort_code = 2'd3;
          end
        end else if (cnt_q == TMO_LAST) begin
          abort      = 1'b1;
          abort_code = 2'd2;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (abort) begin
      state_d    = S_IDLE;
      data_oe_d  = 1'b0;
      error_d    = 1'b1;
      err_code_d = abort_code;
    end

    if (state_d != state_q) begin
      cnt_d = '0;
    end
  end

  // Clock is held low through INHIBIT and RTS; RTS overlaps it with the start bit.
  assign ps2_clk_oe   = (state_q == S_INHIBIT) || (state_q == S_RTS);
  assign ps2_data_oe  = data_oe_q;
  assign bus.cmd_ready = (state_q == S_IDLE);
  assign bus.rx_mask   = (state_q == S_INHIBIT) || (state_q == S_RTS) || (state_q == S_SEND);
  assign bus.done      = done_q;
  assign bus.error     = error_q;
  assign bus.err_code  = err_code_q;

endmodule
